// File: rtl/decode_queue_stage_pkg.sv
// decode_queue_stage_pkg
//   Shared definitions for the RV32IM decode queue stage:
//   - RV32 base opcode constants
//   - alu_control class encodings (upper two bits of alu_control)
//   - decoded_t, the control bundle produced by rv32_decode_comb and
//     held in the queue storage of decode_queue_stage
//   The program counter fields are kept out of the struct because their
//   width is a parameter of the top module.
package decode_queue_stage_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] CLS_R    = 2'b00;
  localparam logic [1:0] CLS_IMM  = 2'b01;
  localparam logic [1:0] CLS_BR   = 2'b10;
  localparam logic [1:0] CLS_ADDR = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  read_sel1;
    logic [4:0]  read_sel2;
    logic [4:0]  write_sel;
    logic        wen;
    logic [31:0] imm32;
    logic [5:0]  alu_control;
    logic        mul_en;
    logic        div_en;
    logic [2:0]  md_op;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/decode_queue_stage_if.sv
// decode_queue_stage_if
//   Bundles the fetch-side and execute-side signals of decode_queue_stage.
//   slave  : view used by the decode stage itself
//   master : view used by the environment (fetch, execute, ALU flush)
//   Signals: in_valid/in_ready/pc/instruction (fetch side), flush,
//   out_valid/out_ready plus the decoded bundle fields (execute side),
//   count (occupancy).
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high and flush is low. in_ready is a function of occupancy only;
// out_valid means the head entry is meaningful. Neither ready depends
// combinationally on the other side's ready.
interface decode_queue_stage_if #(
  parameter int ADDRESS_BITS = 16,
  parameter int DEPTH        = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [ADDRESS_BITS-1:0] pc;
  logic [31:0]             instruction;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [6:0]              op;
  logic [2:0]              funct3;
  logic [6:0]              funct7;
  logic [4:0]              read_sel1;
  logic [4:0]              read_sel2;
  logic [4:0]              write_sel;
  logic                    wen;
  logic [31:0]             imm32;
  logic [ADDRESS_BITS-1:0] pc_o;
  logic [ADDRESS_BITS-1:0] target_pc;
  logic [5:0]              alu_control;
  logic                    mul_en;
  logic                    div_en;
  logic [2:0]              md_op;
  logic                    illegal;
  logic [CW-1:0]           count;

  modport slave (
    input  in_valid, pc, instruction, flush, out_ready,
    output in_ready, out_valid, op, funct3, funct7, read_sel1, read_sel2,
           write_sel, wen, imm32, pc_o, target_pc, alu_control, mul_en,
           div_en, md_op, illegal, count
  );

  modport master (
    output in_valid, pc, instruction, flush, out_ready,
    input  in_ready, out_valid, op, funct3, funct7, read_sel1, read_sel2,
           write_sel, wen, imm32, pc_o, target_pc, alu_control, mul_en,
           div_en, md_op, illegal, count
  );
endinterface

// File: rtl/rv32_decode_comb.sv
// rv32_decode_comb
//   Purely combinational RV32I(M) instruction decode into a decoded_t bundle.
//   Ports:
//     instruction  in   32-bit raw instruction word
//     bundle       out  decoded control bundle
//   Configuration macro RV32M_EN: when defined, OP with funct7 = 0000001
//   decodes to mul/div dispatch; when undefined that encoding is illegal
//   and mul_en/div_en/md_op stay 0.
import decode_queue_stage_pkg::*;

module rv32_decode_comb (
  input  logic [31:0] instruction,
  output decoded_t    bundle
);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  always_comb begin
    bundle           = '0;
    bundle.op        = instruction[6:0];
    bundle.funct3    = instruction[14:12];
    bundle.funct7    = instruction[31:25];
    bundle.read_sel1 = instruction[19:15];
    bundle.read_sel2 = instruction[24:20];
    bundle.write_sel = instruction[11:7];

    case (instruction[6:0])
      OPC_OP: begin
        if (bundle.funct7 == F7_BASE || bundle.funct7 == F7_ALT) begin
          bundle.wen         = 1'b1;
          bundle.alu_control = {CLS_R, bundle.funct7[5], bundle.funct3};
        end
`ifdef RV32M_EN
        else if (bundle.funct7 == F7_MD) begin
          // M-extension goes to the mul/div unit; the ALU sees a zero code.
          bundle.wen    = 1'b1;
          bundle.mul_en = ~bundle.funct3[2];
          bundle.div_en = bundle.funct3[2];
          bundle.md_op  = bundle.funct3;
        end
`endif
        else begin
          bundle.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        bundle.wen   = 1'b1;
        bundle.imm32 = imm_i;
        // funct7[5] only distinguishes SRAI from SRLI; elsewhere it is
        // part of the immediate and must not leak into the ALU code.
        bundle.alu_control = {CLS_IMM,
                              (bundle.funct3 == 3'b101) ? bundle.funct7[5] : 1'b0,
                              bundle.funct3};
      end
      OPC_LOAD, OPC_JALR: begin
        bundle.wen         = 1'b1;
        bundle.imm32       = imm_i;
        bundle.alu_control = {CLS_ADDR, 4'b0};
      end
      OPC_STORE: begin
        bundle.imm32       = imm_s;
        bundle.alu_control = {CLS_ADDR, 4'b0};
      end
      OPC_BRANCH: begin
        bundle.imm32       = imm_b;
        bundle.alu_control = {CLS_BR, 1'b0, bundle.funct3};
      end
      OPC_JAL: begin
        bundle.wen         = 1'b1;
        bundle.imm32       = imm_j;
        bundle.alu_control = {CLS_ADDR, 4'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        bundle.wen         = 1'b1;
        bundle.imm32       = imm_u;
        bundle.alu_control = {CLS_ADDR, 4'b0};
      end
      default: begin
        bundle.illegal = 1'b1;
      end
    endcase

    // x0 is never written.
    if (bundle.write_sel == 5'd0) bundle.wen = 1'b0;
  end

endmodule

// File: rtl/decode_queue_stage.sv
// decode_queue_stage
//   Registered RV32IM decode stage: decodes each accepted instruction and
//   buffers the bundle in a DEPTH-entry FIFO between fetch and issue.
//   Ports:
//     clk  in  rising-edge clock
//     rst  in  synchronous active-high reset
//     bus  decode_queue_stage_if.slave (fetch handshake, flush, execute
//          handshake, decoded head bundle, occupancy count)
//   Parameters: ADDRESS_BITS (pc width), DEPTH (entries, power of two, >= 2)
//   Configuration macro RV32M_EN selects M-extension decode (see
//   rv32_decode_comb).
import decode_queue_stage_pkg::*;

module decode_queue_stage #(
  parameter int ADDRESS_BITS = 16,
  parameter int DEPTH        = 2
) (
  input logic                clk,
  input logic                rst,
  decode_queue_stage_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  decoded_t                dec;
  decoded_t                mem_b  [DEPTH];
  logic [ADDRESS_BITS-1:0] mem_pc [DEPTH];
  logic [PW-1:0]           head, tail;
  logic [CW-1:0]           cnt;
  logic                    push, pop;
  decoded_t                head_b;
  logic [ADDRESS_BITS-1:0] head_pc;

  rv32_decode_comb u_decode (
    .instruction (bus.instruction),
    .bundle      (dec)
  );

  assign bus.in_ready  = (cnt < CW'(DEPTH));
  assign bus.out_valid = (cnt != '0);
  assign bus.count     = cnt;

  assign push = bus.in_valid  & bus.in_ready  & ~bus.flush;
  assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;

  // Pointers are PW bits wide, so wrap modulo DEPTH comes for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (bus.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_b[tail]  <= dec;
      mem_pc[tail] <= bus.pc;
    end
  end

  always_comb begin
    head_b  = '0;
    head_pc = '0;
    if (cnt != '0) begin
      head_b  = mem_b[head];
      head_pc = mem_pc[head];
    end
  end

  assign bus.op          = head_b.op;
  assign bus.funct3      = head_b.funct3;
  assign bus.funct7      = head_b.funct7;
  assign bus.read_sel1   = head_b.read_sel1;
  assign bus.read_sel2   = head_b.read_sel2;
  assign bus.write_sel   = head_b.write_sel;
  assign bus.wen         = head_b.wen;
  assign bus.imm32       = head_b.imm32;
  assign bus.alu_control = head_b.alu_control;
  assign bus.mul_en      = head_b.mul_en;
  assign bus.div_en      = head_b.div_en;
  assign bus.md_op       = head_b.md_op;
  assign bus.illegal     = head_b.illegal;
  assign bus.pc_o        = head_pc;
  assign bus.target_pc   = head_pc + head_b.imm32[ADDRESS_BITS-1:0];

endmodule

// File: tb/tb_decode_queue_stage.sv
// tb_decode_queue_stage
//   Directed bench for decode_queue_stage (ADDRESS_BITS = 16, DEPTH = 2).
//   Expected values are hand-computed from the instruction encodings.
//   Honours RV32M_EN for the mul/div expectations.
module tb_decode_queue_stage;

  localparam int AB    = 16;
  localparam int DEPTH = 2;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  logic [AB-1:0] exp_q[$];

  decode_queue_stage_if #(.ADDRESS_BITS(AB), .DEPTH(DEPTH)) bus ();

  decode_queue_stage #(.ADDRESS_BITS(AB), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.pc          = '0;
    bus.instruction = '0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b0;
  endtask

  task automatic push_one(input logic [AB-1:0] p, input logic [31:0] ins);
    bus.in_valid    = 1'b1;
    bus.pc          = p;
    bus.instruction = ins;
    bus.out_ready   = 1'b0;
    tick();
    bus.in_valid    = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total_cnt++;
    if ({bus.out_valid, bus.count, bus.in_ready} !== {1'b0, 2'd0, 1'b1})
      $display("FAIL reset_handshake: got v=%b c=%0d r=%b want v=0 c=0 r=1",
               bus.out_valid, bus.count, bus.in_ready);
    else pass_cnt++;
    total_cnt++;
    if ({bus.imm32, bus.alu_control, bus.write_sel, bus.wen, bus.pc_o, bus.target_pc, bus.illegal} !== '0)
      $display("FAIL reset_bundle: got imm=%h alu=%b rd=%0d wen=%b pc=%h tgt=%h ill=%b want all 0",
               bus.imm32, bus.alu_control, bus.write_sel, bus.wen, bus.pc_o, bus.target_pc, bus.illegal);
    else pass_cnt++;
  endtask

  task automatic test_addi_latency();
    push_one(16'h0000, 32'h00500113);
    total_cnt++;
    if ({bus.out_valid, bus.count} !== {1'b1, 2'd1})
      $display("FAIL addi_valid: got v=%b c=%0d want v=1 c=1", bus.out_valid, bus.count);
    else pass_cnt++;
    total_cnt++;
    if ({bus.write_sel, bus.read_sel1, bus.wen} !== {5'd2, 5'd0, 1'b1})
      $display("FAIL addi_regs: got rd=%0d rs1=%0d wen=%b want rd=2 rs1=0 wen=1",
               bus.write_sel, bus.read_sel1, bus.wen);
    else pass_cnt++;
    total_cnt++;
    if ({bus.imm32, bus.alu_control} !== {32'd5, 6'b010000})
      $display("FAIL addi_imm_alu: got imm=%h alu=%b want imm=5 alu=010000", bus.imm32, bus.alu_control);
    else pass_cnt++;
    drain();
    total_cnt++;
    if ({bus.out_valid, bus.count} !== {1'b0, 2'd0})
      $display("FAIL addi_drain: got v=%b c=%0d want v=0 c=0", bus.out_valid, bus.count);
    else pass_cnt++;
  endtask

  typedef struct packed {
    logic [AB-1:0] pc;
    logic [31:0]   ins;
    logic [31:0]   imm;
    logic [5:0]    alu;
    logic          wen;
    logic          ill;
    logic [AB-1:0] tgt;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
  } vec_t;

  task automatic test_decode_table();
    vec_t v [10];
    v[0] = '{16'h0004, 32'hFF718393, 32'hFFFFFFF7, 6'b010000, 1'b1, 1'b0, 16'hFFFB, 5'd3, 5'd23, 5'd7};
    v[1] = '{16'h0040, 32'h02728863, 32'd48,       6'b100000, 1'b0, 1'b0, 16'h0070, 5'd5, 5'd7,  5'd16};
    v[2] = '{16'h0008, 32'h40315093, 32'h00000403, 6'b011101, 1'b1, 1'b0, 16'h040B, 5'd2, 5'd3,  5'd1};
    v[3] = '{16'h000C, 32'h402081B3, 32'd0,        6'b001000, 1'b1, 1'b0, 16'h000C, 5'd1, 5'd2,  5'd3};
    v[4] = '{16'h0100, 32'h008000EF, 32'd8,        6'b110000, 1'b1, 1'b0, 16'h0108, 5'd0, 5'd8,  5'd1};
    v[5] = '{16'h0020, 32'h123452B7, 32'h12345000, 6'b110000, 1'b1, 1'b0, 16'h5020, 5'd8, 5'd3,  5'd5};
    v[6] = '{16'h0024, 32'h00000013, 32'd0,        6'b010000, 1'b0, 1'b0, 16'h0024, 5'd0, 5'd0,  5'd0};
    v[7] = '{16'h0028, 32'h0000007F, 32'd0,        6'b000000, 1'b0, 1'b1, 16'h0028, 5'd0, 5'd0,  5'd0};
    v[8] = '{16'h002C, 32'h0C2081B3, 32'd0,        6'b000000, 1'b0, 1'b1, 16'h002C, 5'd1, 5'd2,  5'd3};
    v[9] = '{16'h0030, 32'hFE512E23, 32'hFFFFFFFC, 6'b110000, 1'b0, 1'b0, 16'h002C, 5'd2, 5'd5,  5'd28};
    for (int i = 0; i < 10; i++) begin
      push_one(v[i].pc, v[i].ins);
      total_cnt++;
      if (bus.imm32 !== v[i].imm)
        $display("FAIL dec%0d_imm: got %h want %h", i, bus.imm32, v[i].imm);
      else pass_cnt++;
      total_cnt++;
      if ({bus.alu_control, bus.wen, bus.illegal} !== {v[i].alu, v[i].wen, v[i].ill})
        $display("FAIL dec%0d_ctrl: got alu=%b wen=%b ill=%b want alu=%b wen=%b ill=%b",
                 i, bus.alu_control, bus.wen, bus.illegal, v[i].alu, v[i].wen, v[i].ill);
      else pass_cnt++;
      total_cnt++;
      if ({bus.pc_o, bus.target_pc} !== {v[i].pc, v[i].tgt})
        $display("FAIL dec%0d_pc: got pc=%h tgt=%h want pc=%h tgt=%h",
                 i, bus.pc_o, bus.target_pc, v[i].pc, v[i].tgt);
      else pass_cnt++;
      total_cnt++;
      if ({bus.read_sel1, bus.read_sel2, bus.write_sel} !== {v[i].rs1, v[i].rs2, v[i].rd})
        $display("FAIL dec%0d_regs: got rs1=%0d rs2=%0d rd=%0d want rs1=%0d rs2=%0d rd=%0d",
                 i, bus.read_sel1, bus.read_sel2, bus.write_sel, v[i].rs1, v[i].rs2, v[i].rd);
      else pass_cnt++;
      drain();
    end
  endtask

  task automatic test_muldiv();
    logic [31:0] words [2];
    logic [6:0]  exp_ctrl [2];
    words[0] = 32'h024182B3;  // mul x5,x3,x4
    words[1] = 32'h0241C2B3;  // div x5,x3,x4
`ifdef RV32M_EN
    // {mul_en, div_en, md_op, illegal, wen}
    exp_ctrl[0] = {1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
    exp_ctrl[1] = {1'b0, 1'b1, 3'd4, 1'b0, 1'b1};
`else
    exp_ctrl[0] = {1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
    exp_ctrl[1] = {1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
`endif
    for (int i = 0; i < 2; i++) begin
      push_one(16'h0050, words[i]);
      total_cnt++;
      if ({bus.mul_en, bus.div_en, bus.md_op, bus.illegal, bus.wen} !== exp_ctrl[i])
        $display("FAIL md%0d_ctrl: got mul=%b div=%b md=%0d ill=%b wen=%b want %b",
                 i, bus.mul_en, bus.div_en, bus.md_op, bus.illegal, bus.wen, exp_ctrl[i]);
      else pass_cnt++;
      total_cnt++;
      if ({bus.alu_control, bus.write_sel} !== {6'd0, 5'd5})
        $display("FAIL md%0d_alu: got alu=%b rd=%0d want alu=0 rd=5", i, bus.alu_control, bus.write_sel);
      else pass_cnt++;
      drain();
    end
  endtask

  task automatic test_full_flush();
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.pc          = 16'h0010;
    bus.instruction = 32'h00500113;
    tick();
    bus.pc = 16'h0014;
    tick();
    total_cnt++;
    if ({bus.count, bus.in_ready, bus.pc_o} !== {2'd2, 1'b0, 16'h0010})
      $display("FAIL full_state: got c=%0d r=%b pc=%h want c=2 r=0 pc=0010", bus.count, bus.in_ready, bus.pc_o);
    else pass_cnt++;
    bus.pc = 16'h0018;
    tick();
    total_cnt++;
    if ({bus.count, bus.pc_o} !== {2'd2, 16'h0010})
      $display("FAIL full_hold: got c=%0d pc=%h want c=2 pc=0010", bus.count, bus.pc_o);
    else pass_cnt++;
    // pop while full: the blocked push must not sneak in this cycle
    bus.out_ready = 1'b1;
    tick();
    total_cnt++;
    if ({bus.count, bus.pc_o, bus.in_ready} !== {2'd1, 16'h0014, 1'b1})
      $display("FAIL full_pop: got c=%0d pc=%h r=%b want c=1 pc=0014 r=1", bus.count, bus.pc_o, bus.in_ready);
    else pass_cnt++;
    bus.out_ready = 1'b0;
    tick();
    total_cnt++;
    if (bus.count !== 2'd2)
      $display("FAIL refill: got c=%0d want c=2", bus.count);
    else pass_cnt++;
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    bus.pc        = 16'h001C;
    tick();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    total_cnt++;
    if ({bus.count, bus.out_valid, bus.in_ready} !== {2'd0, 1'b0, 1'b1})
      $display("FAIL flush_state: got c=%0d v=%b r=%b want c=0 v=0 r=1", bus.count, bus.out_valid, bus.in_ready);
    else pass_cnt++;
    total_cnt++;
    if ({bus.imm32, bus.pc_o, bus.wen, bus.write_sel} !== '0)
      $display("FAIL flush_bundle: got imm=%h pc=%h wen=%b rd=%0d want 0", bus.imm32, bus.pc_o, bus.wen, bus.write_sel);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.count !== 2'd0)
      $display("FAIL flush_drop: got c=%0d want c=0", bus.count);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [AB-1:0] want_pc;
    logic [4:0]    want_rd;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.in_valid    = 1'b1;
      bus.pc          = AB'(16'h0200 + 4 * k);
      bus.instruction = (32'(k) << 20) | (32'(k + 1) << 7) | 32'h13;
      exp_q.push_back(bus.pc);
      tick();
      want_pc = exp_q.pop_front();
      want_rd = 5'(k + 1);
      total_cnt++;
      if ({bus.out_valid, bus.count} !== {1'b1, 2'd1})
        $display("FAIL stream%0d_occ: got v=%b c=%0d want v=1 c=1", k, bus.out_valid, bus.count);
      else pass_cnt++;
      total_cnt++;
      if ({bus.pc_o, bus.write_sel, bus.imm32} !== {want_pc, want_rd, 32'(k)})
        $display("FAIL stream%0d_head: got pc=%h rd=%0d imm=%0d want pc=%h rd=%0d imm=%0d",
                 k, bus.pc_o, bus.write_sel, bus.imm32, want_pc, want_rd, k);
      else pass_cnt++;
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    total_cnt++;
    if ({bus.out_valid, bus.count} !== {1'b0, 2'd0})
      $display("FAIL stream_end: got v=%b c=%0d want v=0 c=0", bus.out_valid, bus.count);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    push_one(16'h0300, 32'h00500113);
    bus.in_valid  = 1'b1;
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    total_cnt++;
    if ({bus.out_valid, bus.count, bus.in_ready, bus.imm32} !== {1'b0, 2'd0, 1'b1, 32'd0})
      $display("FAIL rst_mid: got v=%b c=%0d r=%b imm=%h want v=0 c=0 r=1 imm=0",
               bus.out_valid, bus.count, bus.in_ready, bus.imm32);
    else pass_cnt++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    idle_inputs();
    test_reset();
    test_addi_latency();
    test_decode_table();
    test_muldiv();
    test_full_flush();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/decode_queue_stage.md
# decode_queue_stage

Registered RV32IM decode stage that sits between fetch and the ALU/mult-div issue logic. Each accepted instruction is decoded into a full control bundle: register selects, immediate, ALU control, mul/div enables, branch target, illegal flag. Bundles are buffered in a parametrised FIFO with valid/ready handshakes on both sides. A flush input from the ALU discards all in-flight entries on a taken branch or JALR.

## Interface
Parameters:
- ADDRESS_BITS, 16, width of pc, pc_o and target_pc
- DEPTH, 2, number of decoded-bundle entries; power of two, ≥2

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch presents pc/instruction
- in_ready  out  1  stage can accept (count < DEPTH)
- pc  in  ADDRESS_BITS  instruction address
- instruction  in  32  raw instruction word
- flush  in  1  branch taken / JALR redirect from ALU
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head
- op / funct3 / funct7  out  7/3/7  decoded fields
- read_sel1 / read_sel2 / write_sel  out  5 each  rs1 / rs2 / rd
- wen  out  1  register write enable
- imm32  out  32  sign-extended immediate
- pc_o  out  ADDRESS_BITS  pc of head entry
- target_pc  out  ADDRESS_BITS  pc + imm32, truncated to ADDRESS_BITS
- alu_control  out  6  ALU operation code
- mul_en / div_en  out  1 each  M-extension dispatch
- md_op  out  3  mul/div sub-operation (funct3)
- illegal  out  1  unsupported encoding
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Push: in_valid && in_ready && !flush. The decoded bundle of pc/instruction is written at the tail.
- Pop: out_valid && out_ready && !flush. The head advances.
- Push and pop in the same cycle: both occur; count is unchanged.
- in_ready depends only on count, never on out_ready. There is no combinational path from ready to ready.
- flush: count, head and tail are set to 0 next cycle. Any concurrent push or pop is ignored. flush has priority over everything except rst.
- Immediates by opcode:
  - I-type (LOAD, OP-IMM, JALR): imm[11:0]
  - S-type: imm[11:5|4:0]
  - B-type: imm[12:1], bit0 = 0
  - U-type: instr[31:12] << 12
  - J-type: imm[20:1], bit0 = 0
  - All immediates are sign-extended to 32 bits. imm32 = 0 for R-type.
- wen = 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR; wen = 0 otherwise. wen is forced to 0 when write_sel = 0.
- alu_control = {class[1:0], funct7[5], funct3}, where class is:
  - 00: R-type
  - 01: OP-IMM; funct7[5] is used only for SRAI, else 0
  - 10: branch
  - 11: address/add (LOAD, STORE, LUI, AUIPC, JAL, JALR); low 4 bits = 0
- OP with funct7 = 0000001: funct3[2] = 0 gives mul_en, funct3[2] = 1 gives div_en. md_op = funct3, and alu_control = 0.
- illegal = 1 for unknown opcodes and for OP with funct7 not in {0000000, 0100000, 0000001}. An illegal bundle is still queued with wen = mul_en = div_en = 0.
- Outputs present the head entry while out_valid = 1. When empty, all bundle outputs are 0.

## Timing
- Reset values: out_valid = 0, count = 0, in_ready = 1 (because DEPTH ≥ 2), all bundle outputs 0.
- Latency: a push in cycle N gives out_valid = 1 in cycle N+1 if the queue was empty.
- Throughput: one instruction per cycle when out_ready is held high.
- Full (count = DEPTH): in_ready = 0. A simultaneous pop does not re-enable push in the same cycle.
- Empty with push: the entry appears next cycle. There is no same-cycle bypass.
- Head/tail pointers wrap modulo DEPTH.
- rst mid-stream: identical to the reset values above, regardless of flush or handshakes.

## Configuration
- RV32M_EN defined: M-extension decode as described above.
- RV32M_EN undefined:
  - funct7 = 0000001 under OP gives illegal = 1.
  - mul_en and div_en are tied to 0; md_op is tied to 0.
  - Mul/div decode logic is removed.

## Structure
- Shared package holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC)
  - alu_control class encodings
  - the decoded-bundle struct typedef
- Sub-module rv32_decode_comb: purely combinational instruction-to-bundle decode, instantiated once at the input.
- The FIFO storage and pointers live in the top module.

## Test plan
- Reset, then push 0x00500113 (addi x2,x0,5) at pc 0 → next cycle: out_valid = 1, write_sel = 2, read_sel1 = 0, imm32 = 5, wen = 1, alu_control = 6'b01_0_000.
- Push 0xFF718393 (addi x7,x3,-9) → imm32 = 0xFFFFFFF7, read_sel1 = 3, write_sel = 7.
- Push 0x02728863 (beq x5,x7) at pc 0x0040 → imm32 = 48, target_pc = 0x0070, wen = 0, read_sel1 = 5, read_sel2 = 7, alu_control = 6'b10_0_000.
- Push 0x024182B3 (mul x5,x3,x4):
  - With RV32M_EN → mul_en = 1, md_op = 0, illegal = 0.
  - Without RV32M_EN → illegal = 1, mul_en = 0.
- Hold out_ready = 0 and push DEPTH instructions → in_ready = 0 and count = DEPTH. Then assert flush for one cycle → count = 0 and out_valid = 0 next cycle; a concurrent in_valid is dropped.
- Stream 8 instructions with out_ready = 1 → one out_valid per cycle, in order, pointers wrap, count stays at 1.
